mul_unit_arbiter: RTL and testbench
===================================

Name: mul_unit_arbiter

Overview:
- Shares one single-precision IEEE754 multiplier unit among NUM_REQ requesters, for example Multi, Div and Sqrt sequencers.
- Each requester fires a one-cycle trig with two operands. The arbiter buffers the request, grants round-robin, drives the unit's operand/trigger interface, waits for the unit's valid, and routes the result back as a one-cycle vld to the owning requester.
- Includes a watchdog so a hung unit cannot deadlock the ALU.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- TIMEOUT, 64, max cycles waiting for mul_result_vld before abort (>=2).
- CNT_W, 7, watchdog counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- sys_clk  input  1  system clock, rising edge.
- sys_rst_n  input  1  asynchronous active-low reset.
- req_data1_in  input  NUM_REQ*32  operand 1 per requester; slice i is [32i+31:32i].
- req_data2_in  input  NUM_REQ*32  operand 2 per requester.
- req_trig  input  NUM_REQ  one-cycle request pulse per requester.
- req_busy  output  NUM_REQ  requester i has a buffered or in-flight request.
- req_vld  output  NUM_REQ  one-cycle result-valid pulse, one-hot.
- req_result_out  output  32  result, meaningful only while a req_vld bit is high.
- req_timeout  output  1  one-cycle pulse coincident with a timed-out req_vld.
- mul_data1_out  output  32  operand 1 to the multiplier unit.
- mul_data2_out  output  32  operand 2 to the multiplier unit.
- mul_trig_out  output  1  one-cycle start pulse to the multiplier unit.
- mul_result_in  input  32  multiplier unit result.
- mul_result_vld  input  1  multiplier unit result valid, one-cycle pulse.

Behaviour:
- Reset values: all outputs 0; pending flags 0; operand buffers 0; state IDLE; round-robin pointer = NUM_REQ-1, so requester 0 has first priority; watchdog 0.
- Capture:
  - req_trig[i] with pending[i]=0 latches both operand slices and sets pending[i] next cycle.
  - req_trig[i] with pending[i]=1 is ignored; the original request is kept.
  - req_busy = pending, registered.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - If any pending, grant the first pending index strictly after the pointer, wrapping modulo NUM_REQ.
  - Register mul_data1_out/mul_data2_out from that buffer, assert mul_trig_out, store the grant index and update the pointer to it, then go to ISSUE.
  - mul_result_vld in IDLE is ignored.
- ISSUE: mul_trig_out is high this cycle only. Deassert it next cycle, clear the watchdog, go to WAIT. Operands are held stable until the transaction ends.
- WAIT:
  - On mul_result_vld: req_result_out <= mul_result_in, req_vld[grant] <= 1, clear pending[grant], go to IDLE.
  - Else the watchdog increments. At TIMEOUT: req_result_out <= 32'h7FC00000 (quiet NaN), req_vld[grant] <= 1, req_timeout <= 1, clear pending[grant], go to IDLE.
  - mul_data*_out return to 0 on exit.
- Latency:
  - req_trig at cycle t gives pending at t+1.
  - From IDLE, mul_trig_out is high at t+2.
  - Unit valid at t+2+L gives req_vld at t+3+L.
  - Back-to-back: the next grant is issued the cycle after req_vld, so mul_trig_out pulses are at least L+2 apart.
- Simultaneous events:
  - Multiple req_trig in one cycle are all captured.
  - req_trig[i] in the same cycle pending[i] is cleared by completion is accepted: pending stays 1 with new operands, and req_vld for the old result is still pulsed.
  - mul_result_vld in the same cycle as the watchdog hitting TIMEOUT: the real result wins and req_timeout = 0.
- Fairness: with all requesters continuously pending, grants rotate 0,1,2,0,...; no requester waits more than NUM_REQ-1 transactions.
- req_result_out holds its last value between pulses. Checkers must only sample it with req_vld.
- Reset mid-operation: everything returns to reset values immediately. Any late mul_result_vld arrives in IDLE and is ignored; no req_vld is produced.

Test Plan:
- Single request: req_trig[0] with 0x40000000 x 0x40400000; unit L=3 returns 0x40C00000. Expect mul_trig_out at t+2, req_vld=3'b001 with 0x40C00000 at t+6, req_busy[0] low at t+7.
- Contention: req_trig=3'b111 in one cycle with distinct operands. Expect mul_trig_out order 0,1,2 with matching mul_data*_out, one req_vld per requester, and 5 cycles between trig pulses at L=3.
- Round-robin wrap: after servicing 2, assert req_trig 3'b101. Expect grant 0 first, then 2.
- Duplicate trig: req_trig[1] again while pending with different operands. Expect the original operands issued and exactly one req_vld[1].
- Timeout: unit never asserts valid, TIMEOUT=64. Expect req_vld with 0x7FC00000 and req_timeout=1 exactly 64 WAIT cycles after ISSUE; arbiter then serves the next pending requester.
- Reset in WAIT: pulse sys_rst_n low, then inject mul_result_vld. Expect all outputs 0, no req_vld, and req_busy=0.

Source files
------------

// File: rtl/mul_unit_arbiter.sv
// rtl/mul_unit_arbiter.sv - round-robin arbiter sharing one FP multiplier among requesters
// Buffers one request per requester, issues to the unit, routes the result back, aborts hung ops.
module mul_unit_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic [NUM_REQ*32-1:0] req_data1_in,
  input  logic [NUM_REQ*32-1:0] req_data2_in,
  input  logic [NUM_REQ-1:0]    req_trig,
  output logic [NUM_REQ-1:0]    req_busy,
  output logic [NUM_REQ-1:0]    req_vld,
  output logic [31:0]           req_result_out,
  output logic                  req_timeout,
  output logic [31:0]           mul_data1_out,
  output logic [31:0]           mul_data2_out,
  output logic                  mul_trig_out,
  input  logic [31:0]           mul_result_in,
  input  logic                  mul_result_vld
);
  localparam int          IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [31:0] QNAN  = 32'h7FC00000;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t r_state, w_next_state;

  logic [NUM_REQ-1:0] r_pending;
  logic [31:0]        r_op1 [NUM_REQ];
  logic [31:0]        r_op2 [NUM_REQ];
  logic [IDX_W-1:0]   r_ptr, r_gnt;
  logic [CNT_W-1:0]   r_wd;
  logic [NUM_REQ-1:0] r_vld;
  logic [31:0]        r_result, r_mul_d1, r_mul_d2;
  logic               r_tout, r_mul_trig;

  logic               w_grant, w_done, w_tout, w_gnt_found;
  logic [IDX_W-1:0]   w_gnt_idx, w_cand;
  logic [NUM_REQ-1:0] w_clear;

  assign req_busy       = r_pending;
  assign req_vld        = r_vld;
  assign req_result_out = r_result;
  assign req_timeout    = r_tout;
  assign mul_data1_out  = r_mul_d1;
  assign mul_data2_out  = r_mul_d2;
  assign mul_trig_out   = r_mul_trig;

  // Scan downwards so the nearest pending index after the pointer is the last one written.
  always_comb begin
    w_gnt_found = 1'b0;
    w_gnt_idx   = '0;
    w_cand      = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_cand = IDX_W'((int'(r_ptr) + k) % NUM_REQ);
      if (r_pending[w_cand]) begin
        w_gnt_found = 1'b1;
        w_gnt_idx   = w_cand;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) r_state <= IDLE;
    else            r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_grant      = 1'b0;
    w_done       = 1'b0;
    w_tout       = 1'b0;
    w_clear      = '0;
    case (r_state)
      IDLE: begin
        if (w_gnt_found) begin
          w_grant      = 1'b1;
          w_next_state = ISSUE;
        end
      end
      ISSUE: w_next_state = WAIT;
      WAIT: begin
        // A real result in the final watchdog cycle beats the abort.
        if (mul_result_vld)                    w_done = 1'b1;
        else if (r_wd == CNT_W'(TIMEOUT - 1)) w_tout = 1'b1;
        if (w_done || w_tout) begin
          w_clear[r_gnt] = 1'b1;
          w_next_state   = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_pending  <= '0;
      r_ptr      <= IDX_W'(NUM_REQ - 1);
      r_gnt      <= '0;
      r_wd       <= '0;
      r_vld      <= '0;
      r_result   <= '0;
      r_tout     <= 1'b0;
      r_mul_d1   <= '0;
      r_mul_d2   <= '0;
      r_mul_trig <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
        r_op1[i] <= '0;
        r_op2[i] <= '0;
      end
    end else begin
      r_vld      <= '0;
      r_tout     <= 1'b0;
      r_mul_trig <= 1'b0;
      // A slot freed this cycle can be re-armed by a trig in the same cycle.
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_trig[i] && (!r_pending[i] || w_clear[i])) begin
          r_op1[i] <= req_data1_in[i*32 +: 32];
          r_op2[i] <= req_data2_in[i*32 +: 32];
        end
      end
      r_pending <= (r_pending & ~w_clear) | req_trig;
      if (w_grant) begin
        r_mul_d1   <= r_op1[w_gnt_idx];
        r_mul_d2   <= r_op2[w_gnt_idx];
        r_mul_trig <= 1'b1;
        r_gnt      <= w_gnt_idx;
        r_ptr      <= w_gnt_idx;
      end
      if (r_state == ISSUE)     r_wd <= '0;
      else if (r_state == WAIT) r_wd <= r_wd + 1'b1;
      if (w_done || w_tout) begin
        r_vld    <= w_clear;
        r_result <= w_done ? mul_result_in : QNAN;
        r_tout   <= w_tout;
        r_mul_d1 <= '0;
        r_mul_d2 <= '0;
      end
    end
  end
endmodule

// File: tb/tb_mul_unit_arbiter.sv
// tb/tb_mul_unit_arbiter.sv - scoreboard bench for mul_unit_arbiter
// Stimulus pushes expected issues/results; a negedge monitor pops and compares.
module tb_mul_unit_arbiter;
  localparam int N  = 3;
  localparam int TO = 64;

  localparam logic [31:0] F0_5 = 32'h3F000000;
  localparam logic [31:0] F1   = 32'h3F800000;
  localparam logic [31:0] F1_5 = 32'h3FC00000;
  localparam logic [31:0] F2   = 32'h40000000;
  localparam logic [31:0] F2_25= 32'h40100000;
  localparam logic [31:0] F3   = 32'h40400000;
  localparam logic [31:0] F4   = 32'h40800000;
  localparam logic [31:0] F5   = 32'h40A00000;
  localparam logic [31:0] F6   = 32'h40C00000;
  localparam logic [31:0] F8   = 32'h41000000;
  localparam logic [31:0] F10  = 32'h41200000;
  localparam logic [31:0] FM2  = 32'hC0000000;
  localparam logic [31:0] FM6  = 32'hC0C00000;
  localparam logic [31:0] QNAN = 32'h7FC00000;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N*32-1:0] d1 = '0;
  logic [N*32-1:0] d2 = '0;
  logic [N-1:0]    trig = '0;
  logic [N-1:0]    req_busy, req_vld;
  logic [31:0]     req_result_out, mul_data1_out, mul_data2_out;
  logic            req_timeout, mul_trig_out;
  logic [31:0]     mres = '0;
  logic            mvld = 1'b0;

  mul_unit_arbiter #(.NUM_REQ(N), .TIMEOUT(TO), .CNT_W(7)) dut (
    .sys_clk(clk), .sys_rst_n(rst_n),
    .req_data1_in(d1), .req_data2_in(d2), .req_trig(trig),
    .req_busy(req_busy), .req_vld(req_vld), .req_result_out(req_result_out),
    .req_timeout(req_timeout),
    .mul_data1_out(mul_data1_out), .mul_data2_out(mul_data2_out), .mul_trig_out(mul_trig_out),
    .mul_result_in(mres), .mul_result_vld(mvld)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [63:0] exp_issue[$];
  logic [35:0] exp_res[$];
  int          trig_q[$];
  int          vld_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          unit_lat = 3;
  int          drop_cnt = 0;
  bit          resp_pend = 1'b0;
  int          resp_due = 0;
  logic [31:0] resp_data = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int qat(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1000;
  endfunction

  function automatic logic [31:0] unit_product(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {F2, F3}:     return F6;
      {F1, F5}:     return F5;
      {F1_5, F1_5}: return F2_25;
      {FM2, F3}:    return FM6;
      {F2, F2}:     return F4;
      {F10, F0_5}:  return F5;
      {F0_5, F8}:   return F4;
      default:      return 32'h0;
    endcase
  endfunction

  // Multiplier unit model: answers L cycles after its trig, or swallows drop_cnt trigs.
  initial begin
    forever begin
      @(posedge clk); #1;
      mvld = 1'b0;
      if (resp_pend && cyc == resp_due) begin
        mvld      = 1'b1;
        mres      = resp_data;
        resp_pend = 1'b0;
      end
      @(negedge clk);
      if (mul_trig_out) begin
        if (drop_cnt > 0) drop_cnt--;
        else begin
          resp_pend = 1'b1;
          resp_due  = cyc + unit_lat;
          resp_data = unit_product(mul_data1_out, mul_data2_out);
        end
      end
    end
  end

  // Monitor
  initial begin
    logic [63:0] ei;
    logic [35:0] er;
    forever begin
      @(negedge clk);
      if (mul_trig_out) begin
        trig_q.push_back(cyc);
        chk("issue_expected", 64'(exp_issue.size() != 0), 64'(1));
        if (exp_issue.size() != 0) begin
          ei = exp_issue.pop_front();
          chk("issue_operands", {mul_data1_out, mul_data2_out}, ei);
        end
      end
      if (req_vld != '0) begin
        vld_q.push_back(cyc);
        chk("result_expected", 64'(exp_res.size() != 0), 64'(1));
        if (exp_res.size() != 0) begin
          er = exp_res.pop_front();
          chk("result", 64'({req_vld, req_timeout, req_result_out}), 64'(er));
        end
      end else begin
        chk("timeout_without_vld", 64'(req_timeout), 64'(0));
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
    d1[i*32 +: 32] = a;
    d2[i*32 +: 32] = b;
  endtask

  task automatic push(input int i, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] res, input logic tout);
    logic [2:0] oh;
    oh = 3'(1 << i);
    exp_issue.push_back({a, b});
    exp_res.push_back({oh, tout, res});
  endtask

  task automatic fire(input logic [N-1:0] t, output int tc);
    trig = t;
    tc = cyc;
    tick();
    trig = '0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while ((exp_res.size() != 0 || exp_issue.size() != 0 || req_busy != '0) && n < 400) begin
      tick();
      n++;
    end
    chk(name, 64'(n < 400), 64'(1));
    tick();
    tick();
  endtask

  task automatic check_zero(input string name);
    chk({name, "_ctl"}, 64'({req_busy, req_vld, req_timeout, mul_trig_out, req_result_out}), 64'(0));
    chk({name, "_ops"}, {mul_data1_out, mul_data2_out}, 64'(0));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    check_zero("reset");
    tick();
    rst_n = 1'b1;
    tick();
    trig_q.delete();
    vld_q.delete();
  endtask

  initial begin
    int t;
    do_reset();

    // Single request, L=3
    set_req(0, F2, F3);
    push(0, F2, F3, F6, 1'b0);
    fire(3'b001, t);
    chk("busy_t1", 64'(req_busy), 64'(3'b001));
    while (cyc < t + 7) tick();
    chk("busy_clear_t7", 64'(req_busy[0]), 64'(0));
    wait_done("single_done");
    chk("single_trig_lat", 64'(qat(trig_q, 0)), 64'(t + 2));
    chk("single_vld_lat", 64'(qat(vld_q, 0)), 64'(t + 6));

    // Contention from reset: 0,1,2, five cycles apart
    do_reset();
    set_req(0, F1, F5);
    set_req(1, F1_5, F1_5);
    set_req(2, FM2, F3);
    push(0, F1, F5, F5, 1'b0);
    push(1, F1_5, F1_5, F2_25, 1'b0);
    push(2, FM2, F3, FM6, 1'b0);
    fire(3'b111, t);
    wait_done("contention_done");
    chk("contention_first", 64'(qat(trig_q, 0)), 64'(t + 2));
    chk("contention_gap01", 64'(qat(trig_q, 1) - qat(trig_q, 0)), 64'(5));
    chk("contention_gap12", 64'(qat(trig_q, 2) - qat(trig_q, 1)), 64'(5));

    // Wrap after serving 2: grant 0 then 2
    set_req(0, F2, F2);
    set_req(2, F10, F0_5);
    push(0, F2, F2, F4, 1'b0);
    push(2, F10, F0_5, F5, 1'b0);
    fire(3'b101, t);
    wait_done("wrap_done");

    // Duplicate trig while pending keeps original operands
    set_req(1, F0_5, F8);
    push(1, F0_5, F8, F4, 1'b0);
    trig = 3'b010;
    tick();
    set_req(1, F3, F3);
    tick();
    trig = '0;
    wait_done("dup_done");

    // Re-arm in the same cycle the slot is cleared
    trig_q.delete();
    set_req(2, F2, F2);
    push(2, F2, F2, F4, 1'b0);
    push(2, F1_5, F1_5, F2_25, 1'b0);
    fire(3'b100, t);
    while (cyc < t + 5) tick();
    set_req(2, F1_5, F1_5);
    trig = 3'b100;
    tick();
    trig = '0;
    chk("rearm_busy", 64'(req_busy[2]), 64'(1));
    wait_done("rearm_done");
    chk("rearm_gap", 64'(qat(trig_q, 1) - qat(trig_q, 0)), 64'(5));

    // Timeout on requester 0, then requester 1 served normally
    trig_q.delete();
    vld_q.delete();
    drop_cnt = 1;
    set_req(0, F2, F3);
    set_req(1, F1, F5);
    push(0, F2, F3, QNAN, 1'b1);
    push(1, F1, F5, F5, 1'b0);
    fire(3'b011, t);
    wait_done("timeout_done");
    chk("timeout_lat", 64'(qat(vld_q, 0) - qat(trig_q, 0)), 64'(TO + 1));
    chk("after_timeout_grant", 64'(qat(trig_q, 1) - qat(vld_q, 0)), 64'(1));
    chk("after_timeout_lat", 64'(qat(vld_q, 1) - qat(trig_q, 1)), 64'(4));

    // Result arriving in the last watchdog cycle wins
    trig_q.delete();
    vld_q.delete();
    unit_lat = TO;
    set_req(2, F2, F3);
    push(2, F2, F3, F6, 1'b0);
    fire(3'b100, t);
    wait_done("edge_done");
    chk("edge_lat", 64'(qat(vld_q, 0) - qat(trig_q, 0)), 64'(TO + 1));

    // Reset while in WAIT; the late unit valid must be ignored
    vld_q.delete();
    unit_lat = 10;
    set_req(0, F2, F3);
    exp_issue.push_back({F2, F3});
    fire(3'b001, t);
    while (cyc < t + 4) tick();
    rst_n = 1'b0;
    tick();
    check_zero("midrst");
    tick();
    rst_n = 1'b1;
    while (cyc < t + 16) tick();
    chk("midrst_late_vld_sent", 64'(resp_pend), 64'(0));
    chk("midrst_busy", 64'(req_busy), 64'(0));
    chk("midrst_no_vld", 64'(vld_q.size()), 64'(0));
    chk("midrst_issue_seen", 64'(exp_issue.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit: got cycle %0d expected completion", cyc);
    $fatal(1);
  end
endmodule
